// File: rtl/mux_reg_pkg.sv
// mux_reg_n shared types: output-register FSM state and constants.
// Optional statistics feature is gated by MUX_REG_N_STATS_EN.
package mux_reg_pkg;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  localparam int SEL_HOLD = 0;
  localparam int STAT_W   = 16;

endpackage

// File: rtl/mux_reg_n_if.sv
// mux_reg_n bus bundle: channel inputs, select, output handshake.
// master drives the mux; slave is the mux itself (MUX_REG_N_STATS_EN ports stay separate).
interface mux_reg_n_if #(
  parameter int DATA_W = 8,
  parameter int NCH    = 3,
  parameter int OUT_W  = 16
);
  localparam int SEL_W = $clog2(NCH + 1);

  logic [NCH*DATA_W-1:0] in_data;
  logic [NCH-1:0]        in_valid;
  logic [NCH-1:0]        in_ready;
  logic [SEL_W-1:0]      select;
  logic [OUT_W-1:0]      out_data;
  logic                  out_valid;
  logic                  out_ready;
  logic                  sel_err;

  modport master (
    output in_data, in_valid, select, out_ready,
    input  in_ready, out_data, out_valid, sel_err
  );

  modport slave (
    input  in_data, in_valid, select, out_ready,
    output in_ready, out_data, out_valid, sel_err
  );

endinterface

// File: rtl/mux_reg_stats.sv
// mux_reg_n per-channel saturating transfer counters.
// Only instantiated when MUX_REG_N_STATS_EN is defined.
module mux_reg_stats
  import mux_reg_pkg::*;
#(
  parameter int NCH   = 3,
  parameter int SEL_W = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NCH-1:0]    xfer,
  input  logic [SEL_W-1:0]  stat_sel,
  output logic [STAT_W-1:0] stat_count
);

  logic [STAT_W-1:0] cnt [NCH];
  logic [STAT_W-1:0] rd;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < NCH; k++) cnt[k] <= '0;
    end else begin
      for (int k = 0; k < NCH; k++)
        if (xfer[k] && cnt[k] != '1)
          cnt[k] <= cnt[k] + 1'b1;
    end
  end

  // indices at or beyond NCH fall through to zero
  always_comb begin
    rd = '0;
    for (int k = 0; k < NCH; k++)
      if (stat_sel == SEL_W'(k)) rd = cnt[k];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) stat_count <= '0;
    else        stat_count <= rd;
  end

endmodule

// File: rtl/mux_reg_n.sv
// mux_reg_n: N-channel select mux feeding a one-word output register.
// Define MUX_REG_N_STATS_EN to add per-channel transfer counters.
module mux_reg_n
  import mux_reg_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int NCH    = 3,
  parameter int OUT_W  = 16,
  localparam int SEL_W = $clog2(NCH + 1)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NCH*DATA_W-1:0] in_data,
  input  logic [NCH-1:0]        in_valid,
  output logic [NCH-1:0]        in_ready,
  input  logic [SEL_W-1:0]      select,
  output logic [OUT_W-1:0]      out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
`ifdef MUX_REG_N_STATS_EN
  input  logic [SEL_W-1:0]      stat_sel,
  output logic [STAT_W-1:0]     stat_count,
`endif
  output logic                  sel_err
);

  state_t              state;
  logic                can_load;
  logic                sel_bad;
  logic [NCH-1:0]      xfer_vec;
  logic                xfer;
  logic [DATA_W-1:0]   sel_data;

  assign can_load = (state == EMPTY) || out_ready;
  assign sel_bad  = 32'(select) > NCH;

  // rst_n gate keeps every in_ready low while reset is held
  always_comb begin
    in_ready = '0;
    for (int k = 0; k < NCH; k++)
      in_ready[k] = rst_n && can_load &&
                    (select == SEL_W'(k + 1));
  end

  always_comb begin
    sel_data = '0;
    for (int k = 0; k < NCH; k++)
      if (select == SEL_W'(k + 1))
        sel_data = in_data[k*DATA_W +: DATA_W];
  end

  assign xfer_vec  = in_ready & in_valid;
  assign xfer      = |xfer_vec;
  assign out_valid = (state == FULL);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= EMPTY;
      out_data <= '0;
      sel_err  <= 1'b0;
    end else begin
      sel_err <= sel_bad;
      if (xfer) begin
        out_data <= OUT_W'(sel_data);
        state    <= FULL;
      end else if (state == FULL && out_ready) begin
        state <= EMPTY;
      end
    end
  end

`ifdef MUX_REG_N_STATS_EN
  mux_reg_stats #(
    .NCH   (NCH),
    .SEL_W (SEL_W)
  ) u_stats (
    .clk        (clk),
    .rst_n      (rst_n),
    .xfer       (xfer_vec),
    .stat_sel   (stat_sel),
    .stat_count (stat_count)
  );
`endif

endmodule

// File: tb/tb_mux_reg_n.sv
// mux_reg_n bench: directed vectors, queue scoreboard on output handshakes.
// Stats checks compile in when MUX_REG_N_STATS_EN is defined.
module tb_mux_reg_n;
  import mux_reg_pkg::*;

  logic clk;
  logic rst_n;

  mux_reg_n_if #(.DATA_W(8), .NCH(3), .OUT_W(16)) bi ();
  mux_reg_n_if #(.DATA_W(8), .NCH(2), .OUT_W(16)) bi2 ();

`ifdef MUX_REG_N_STATS_EN
  logic [1:0]        stat_sel;
  logic [STAT_W-1:0] stat_count;
  logic [STAT_W-1:0] stat_count2;
`endif

  mux_reg_n #(.DATA_W(8), .NCH(3), .OUT_W(16)) u_dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_data   (bi.in_data),
    .in_valid  (bi.in_valid),
    .in_ready  (bi.in_ready),
    .select    (bi.select),
    .out_data  (bi.out_data),
    .out_valid (bi.out_valid),
    .out_ready (bi.out_ready),
`ifdef MUX_REG_N_STATS_EN
    .stat_sel  (stat_sel),
    .stat_count(stat_count),
`endif
    .sel_err   (bi.sel_err)
  );

  mux_reg_n #(.DATA_W(8), .NCH(2), .OUT_W(16)) u_dut2 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_data   (bi2.in_data),
    .in_valid  (bi2.in_valid),
    .in_ready  (bi2.in_ready),
    .select    (bi2.select),
    .out_data  (bi2.out_data),
    .out_valid (bi2.out_valid),
    .out_ready (bi2.out_ready),
`ifdef MUX_REG_N_STATS_EN
    .stat_sel  (2'd0),
    .stat_count(stat_count2),
`endif
    .sel_err   (bi2.sel_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  logic [15:0] sbq [$];
  logic sb_en = 1'b1;

  task automatic check(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // monitor: every accepted output word must match the queue head
  always @(negedge clk) begin
    if (sb_en && rst_n && bi.out_valid && bi.out_ready) begin
      if (sbq.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL sb_underflow: got %0h expected none",
                 bi.out_data);
      end else begin
        check("sb_out_data", 32'(bi.out_data),
              32'(sbq.pop_front()));
      end
    end
  end

  initial begin
    rst_n = 1'b0;
    bi.in_data   = {8'h5A, 8'h3C, 8'hA5};
    bi.in_valid  = 3'b001;
    bi.select    = 2'd1;
    bi.out_ready = 1'b0;
    bi2.in_data   = {8'h3C, 8'hA5};
    bi2.in_valid  = 2'b00;
    bi2.select    = 2'd0;
    bi2.out_ready = 1'b0;
`ifdef MUX_REG_N_STATS_EN
    stat_sel = 2'd0;
`endif
    #3;
    check("rst_out_valid", 32'(bi.out_valid), 0);
    check("rst_out_data", 32'(bi.out_data), 0);
    check("rst_sel_err", 32'(bi.sel_err), 0);
    check("rst_in_ready", 32'(bi.in_ready), 0);
    @(posedge clk);
    #3 rst_n = 1'b1;
    #1;
    check("ch0_in_ready", 32'(bi.in_ready), 32'h1);
    sbq.push_back(16'h00A5);
    tick();
    check("ch0_out_data", 32'(bi.out_data), 32'h00A5);
    check("ch0_out_valid", 32'(bi.out_valid), 1);
    check("full_stall_rdy", 32'(bi.in_ready), 0);

    bi.select    = 2'd2;
    bi.in_valid  = 3'b010;
    bi.out_ready = 1'b1;
    sbq.push_back(16'h003C);
    #1;
    check("reload_in_ready", 32'(bi.in_ready), 32'h2);
    tick();
    check("reload_out_data", 32'(bi.out_data), 32'h003C);
    check("reload_valid", 32'(bi.out_valid), 1);

    bi.select   = 2'd0;
    bi.in_valid = 3'b111;
    #1;
    check("hold_in_ready", 32'(bi.in_ready), 0);
    tick();
    check("drain_valid", 32'(bi.out_valid), 0);
    check("drain_data", 32'(bi.out_data), 32'h003C);

    bi.select    = 2'd3;
    bi.in_valid  = 3'b100;
    bi.out_ready = 1'b0;
    sbq.push_back(16'h005A);
    #1;
    check("ch2_in_ready", 32'(bi.in_ready), 32'h4);
    tick();
    check("ch2_out_data", 32'(bi.out_data), 32'h005A);
    bi.in_valid = 3'b000;
    #1;
    check("ch2_stall_rdy", 32'(bi.in_ready), 0);
    tick();
    check("ch2_held", 32'(bi.out_data), 32'h005A);
    check("ch2_held_v", 32'(bi.out_valid), 1);
    bi.select    = 2'd0;
    bi.out_ready = 1'b1;
    tick();
    check("ch2_drained", 32'(bi.out_valid), 0);
    bi.out_ready = 1'b0;

    bi.in_data  = {8'h5A, 8'h3C, 8'hFF};
    bi.select   = 2'd1;
    bi.in_valid = 3'b001;
    tick();
    check("ff_loaded", 32'(bi.out_data), 32'h00FF);
    #3 rst_n = 1'b0;
    #1;
    check("async_valid", 32'(bi.out_valid), 0);
    check("async_data", 32'(bi.out_data), 0);
    check("async_in_ready", 32'(bi.in_ready), 0);
    @(posedge clk);
    #3 rst_n = 1'b1;
    bi.select   = 2'd0;
    bi.in_valid = 3'b000;
    tick();
    check("post_rst_valid", 32'(bi.out_valid), 0);

    bi2.select   = 2'd1;
    bi2.in_valid = 2'b01;
    tick();
    check("d2_load", 32'(bi2.out_data), 32'h00A5);
    bi2.select   = 2'd3;
    bi2.in_valid = 2'b11;
    #1;
    check("d2_bad_rdy", 32'(bi2.in_ready), 0);
    check("d2_err_pre", 32'(bi2.sel_err), 0);
    tick();
    check("d2_err_pulse", 32'(bi2.sel_err), 1);
    check("d2_err_data", 32'(bi2.out_data), 32'h00A5);
    check("d2_err_valid", 32'(bi2.out_valid), 1);
    bi2.select = 2'd0;
    tick();
    check("d2_err_clear", 32'(bi2.sel_err), 0);
    check("d2_hold_data", 32'(bi2.out_data), 32'h00A5);

`ifdef MUX_REG_N_STATS_EN
    sb_en = 1'b0;
    bi.out_ready = 1'b1;
    bi.select    = 2'd3;
    bi.in_valid  = 3'b100;
    tick();
    tick();
    bi.select   = 2'd1;
    bi.in_valid = 3'b001;
    repeat (70000) @(posedge clk);
    #1;
    bi.select   = 2'd0;
    bi.in_valid = 3'b000;
    stat_sel = 2'd0;
    tick();
    check("stat_ch0_sat", 32'(stat_count), 32'hFFFF);
    stat_sel = 2'd1;
    tick();
    check("stat_ch1_zero", 32'(stat_count), 0);
    stat_sel = 2'd2;
    tick();
    check("stat_ch2_two", 32'(stat_count), 2);
    stat_sel = 2'd3;
    tick();
    check("stat_oob_zero", 32'(stat_count), 0);
    bi.out_ready = 1'b0;
`endif

    check("sb_empty", 32'(sbq.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/mux_reg_n.md
MUX_REG_N -- requirements
Module: mux_reg_n

Interface
REQ-001 SHALL have parameter DATA_W, default 8: per-channel input data width.
REQ-002 SHALL have parameter NCH, default 3: number of input channels, range 2..15.
REQ-003 SHALL have parameter OUT_W, default 16: output width, with OUT_W >= DATA_W.
REQ-004 SHALL derive localparam SEL_W = clog2(NCH+1).
REQ-005 SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-006 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-007 SHALL have port in_data, input, NCH*DATA_W bits: channel k occupies bits [k*DATA_W +: DATA_W].
REQ-008 SHALL have port in_valid, input, NCH bits: per-channel data valid.
REQ-009 SHALL have port in_ready, output, NCH bits: per-channel accept.
REQ-010 SHALL have port select, input, SEL_W bits: 0 = hold; k in 1..NCH = channel k-1; any value > NCH is invalid.
REQ-011 SHALL have port out_data, output, OUT_W bits: registered result.
REQ-012 SHALL have port out_valid, output, 1 bit: out_data holds an unconsumed word.
REQ-013 SHALL have port out_ready, input, 1 bit: consumer accepts out_data.
REQ-014 SHALL have port sel_err, output, 1 bit: registered one-cycle pulse on an invalid select.

Function
REQ-015 SHALL implement a two-state FSM: EMPTY (out_valid=0) and FULL (out_valid=1).
REQ-016 SHALL define can_load = EMPTY, or FULL with out_ready=1.
REQ-017 SHALL drive in_ready[k-1] combinationally high only when select=k and can_load; all other in_ready bits SHALL be 0.
REQ-018 SHALL register on a transfer (select=k, in_valid[k-1], can_load): out_data <= zero-extended channel k-1 data, go/stay FULL; latency 1 cycle.
REQ-019 SHALL transition FULL -> EMPTY with out_data unchanged when out_ready=1 and no transfer occurs.
REQ-020 SHALL, when select=0, accept nothing and hold out_data/out_valid except for the drain in REQ-019.
REQ-021 SHALL treat select > NCH as hold, and SHALL set sel_err=1 in the following cycle only.
REQ-022 SHALL perform drain and reload in the same cycle when out_ready and a transfer coincide, with out_valid remaining 1 and no bubble.
REQ-023 SHALL have no combinational path from in_data to out_data.

Reset
REQ-024 SHALL, while rst_n=0, force state EMPTY, out_data=0, out_valid=0, sel_err=0, and all statistics counters to 0, independent of clk.
REQ-025 SHALL, on reset mid-transfer, discard the pending word; no in_ready SHALL be asserted while rst_n=0.

Configuration
REQ-026 SHALL, with MUX_REG_N_STATS_EN defined, add per-channel 16-bit saturating transfer counters, input stat_sel[SEL_W-1:0] (a channel index), and output stat_count[15:0] (registered, 1-cycle latency).
REQ-027 SHALL, with MUX_REG_N_STATS_EN defined, hold each counter at 0xFFFF once it saturates; stat_sel >= NCH SHALL read 0.
REQ-028 SHALL, without MUX_REG_N_STATS_EN, omit the stat ports and counters entirely, with the remaining behaviour identical.

Structure
REQ-029 SHALL place the FSM state typedef (EMPTY/FULL), SEL_HOLD=0, and STAT_W=16 in shared package mux_reg_pkg.
REQ-030 SHALL place the statistics logic in sub-module mux_reg_stats, instantiated only under MUX_REG_N_STATS_EN.

Verification
REQ-031 SHALL cover: defaults, select=1, in_valid=001, in_data A=0xA5, out_ready=0 -> next cycle out_data=0x00A5, out_valid=1, in_ready then 0.
REQ-032 SHALL cover: FULL, select=2, B=0x3C, out_ready=1 -> same-cycle in_ready[1]=1; next out_data=0x003C, out_valid stays 1.
REQ-033 SHALL cover: FULL, select=0, out_ready=1 for 1 cycle -> out_valid=0, out_data unchanged, no in_ready asserted.
REQ-034 SHALL cover: NCH=3, select=3'b... value 3? no -> with SEL_W=2 use NCH=2, select=3 -> sel_err pulse for exactly 1 cycle, outputs held.
REQ-035 SHALL cover: rst_n low mid-cycle while FULL with 0xFF -> out_valid=0, out_data=0 immediately, before the next clk edge.
REQ-036 SHALL cover: STATS_EN, 70000 transfers on channel 0 -> stat_sel=0 reads 0xFFFF; channel 1 reads 0.
